// File: rtl/seg7_scan_disp_if.sv
// Bundle between a value producer and the multiplexed 7-segment driver.
// The bundle carries the load strobe with its captured fields, and the scanned pin outputs.
interface seg7_scan_disp_if #(
  parameter int DIGITS = 8
);
  // load is a one-cycle strobe with no ready: it is always accepted, and the
  // last strobe inside a frame is the one that reaches the display.
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp_in;
  logic                  blank_lz;
  logic [DIGITS-1:0]     blink_mask;
  logic [6:0]            seg_out;
  logic                  dp_out;
  logic [DIGITS-1:0]     an_out;
  logic                  frame_done;

  modport master (
    output load, value, dp_in, blank_lz, blink_mask,
    input  seg_out, dp_out, an_out, frame_done
  );

  modport slave (
    input  load, value, dp_in, blank_lz, blink_mask,
    output seg_out, dp_out, an_out, frame_done
  );
endinterface

// File: rtl/seg7_scan_disp.sv
// Time-multiplexed hex display driver: shadow/display double buffer swapped at frame
// boundaries, with leading-zero blanking, per-digit blink and decimal points.
module seg7_scan_disp #(
  parameter int DIGITS       = 8,
  parameter int CLK_DIV      = 1000,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic            clk,
  input  logic            rst,
  seg7_scan_disp_if.slave bus
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(CLK_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  // Everything is built active-low internally; POL flips it at the pins.
  localparam logic POL = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

  typedef struct packed {
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic                blank_lz;
    logic [DIGITS-1:0]   blink;
  } disp_t;

  logic [PW-1:0]     presc;
  logic [IW-1:0]     idx;
  logic [BW-1:0]     bcnt;
  logic              blink_ph;
  logic              pending;
  disp_t             shadow;
  disp_t             disp;
  disp_t             in_word;
  logic [6:0]        seg_q;
  logic              dp_q;
  logic [DIGITS-1:0] an_q;
  logic              fd_q;

  logic              presc_tc;
  logic              wrap;
  logic              run;
  logic [DIGITS-1:0] lz;
  logic [3:0]        cur_digit;
  logic              cur_blank;
  logic              cur_dp;
  logic [DIGITS-1:0] an_on;
  logic [6:0]        seg_lo;
  logic              dp_lo;
  logic [DIGITS-1:0] an_lo;
  logic [6:0]        seg_n;
  logic              dp_n;
  logic [DIGITS-1:0] an_n;

  assign in_word  = {bus.value, bus.dp_in, bus.blank_lz, bus.blink_mask};
  assign presc_tc = (presc == PW'(CLK_DIV - 1));
  assign wrap     = presc_tc && (idx == IW'(DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      idx      <= '0;
      bcnt     <= '0;
      blink_ph <= 1'b0;
      pending  <= 1'b0;
      shadow   <= '0;
      disp     <= '0;
      seg_q    <= {7{~POL}};
      dp_q     <= ~POL;
      an_q     <= {DIGITS{~POL}};
      fd_q     <= 1'b0;
    end else begin
      if (presc_tc) begin
        presc <= '0;
        idx   <= wrap ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      fd_q <= wrap;
      if (wrap) begin
        if (bcnt == BW'(BLINK_FRAMES - 1)) begin
          bcnt     <= '0;
          blink_ph <= ~blink_ph;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
      if (bus.load) shadow <= in_word;
      // A load coinciding with the wrap bypasses the shadow so it is not a frame late.
      if (bus.load && wrap) begin
        disp    <= in_word;
        pending <= 1'b0;
      end else if (bus.load) begin
        pending <= 1'b1;
      end else if (wrap && pending) begin
        disp    <= shadow;
        pending <= 1'b0;
      end
      seg_q <= seg_n;
      dp_q  <= dp_n;
      an_q  <= an_n;
    end
  end

  always_comb begin
    run       = 1'b1;
    lz        = '0;
    cur_digit = 4'h0;
    cur_blank = 1'b0;
    cur_dp    = 1'b0;
    an_on     = '0;
    seg_lo    = 7'h7F;
    dp_lo     = 1'b1;
    an_lo     = '1;
    // lz[i] is set when digit i and every digit above it are zero.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run   = run && (disp.value[4*i +: 4] == 4'h0);
      lz[i] = run;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_digit = disp.value[4*i +: 4];
        cur_blank = (disp.blank_lz && lz[i] && (i != 0)) || (disp.blink[i] && blink_ph);
        cur_dp    = disp.dp[i];
        an_on[i]  = 1'b1;
      end
    end
    case (cur_digit)
      4'h0: seg_lo = 7'b0000001;
      4'h1: seg_lo = 7'b1001111;
      4'h2: seg_lo = 7'b0010010;
      4'h3: seg_lo = 7'b0000110;
      4'h4: seg_lo = 7'b1001100;
      4'h5: seg_lo = 7'b0100100;
      4'h6: seg_lo = 7'b0100000;
      4'h7: seg_lo = 7'b0001111;
      4'h8: seg_lo = 7'b0000000;
      4'h9: seg_lo = 7'b0001100;
      4'hA: seg_lo = 7'b0001000;
      4'hB: seg_lo = 7'b1100000;
      4'hC: seg_lo = 7'b0110001;
      4'hD: seg_lo = 7'b1000010;
      4'hE: seg_lo = 7'b0110000;
      default: seg_lo = 7'b0111000;
    endcase
    if (cur_blank) begin
      seg_lo = 7'h7F;
      dp_lo  = 1'b1;
      an_lo  = '1;
    end else begin
      dp_lo = ~cur_dp;
      an_lo = ~an_on;
    end
    seg_n = seg_lo ^ {7{POL}};
    dp_n  = dp_lo ^ POL;
    an_n  = an_lo ^ {DIGITS{POL}};
  end

  assign bus.seg_out    = seg_q;
  assign bus.dp_out     = dp_q;
  assign bus.an_out     = an_q;
  assign bus.frame_done = fd_q;
endmodule
